// File: rtl/spi_sensor_frame_master.sv
// Burst SPI master (mode 0): runs num_frames 16-bit full-duplex frames per start and streams each MISO word out.
// Define SPI_MASTER_LOOPBACK_EN to add loopback_sel, which feeds MOSI back into the receive path.
module spi_sensor_frame_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_frames,
  input  logic [15:0]      cmd_word,
  input  logic             MISO_from_sensor,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic             loopback_sel,
`endif
  output logic             MOSI_to_sensor,
  output logic             SCLK_wire,
  output logic             CS_b_wire,
  output logic             sample_CLK_out,
  output logic [15:0]      rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] rx_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      tx_sh;
  logic [15:0]      rx_sh;
  logic [CNT_W-1:0] frames_left;
  logic [CNT_W-1:0] frame_idx;
  logic             miso;
  logic             half_end;
  logic             frame_begin;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign miso = loopback_sel ? MOSI_to_sensor : MISO_from_sensor;
`else
  assign miso = MISO_from_sensor;
`endif

  assign half_end       = (cnt == HALF_LAST);
  assign frame_begin    = (state == IDLE || state == GAP) && (next_state == SETUP);
  assign sample_CLK_out = ~CS_b_wire;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start && num_frames != '0) next_state = SETUP;
      SETUP: if (half_end) next_state = SHIFT;
      // The 16th falling SCLK edge ends the shift phase.
      SHIFT: if (half_end && SCLK_wire && bit_cnt == 4'd15) next_state = HOLD;
      HOLD:  if (half_end) next_state = GAP;
      GAP:   if (cnt == GAP_LAST) next_state = (frames_left != '0) ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt            <= '0;
      bit_cnt        <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      frames_left    <= '0;
      frame_idx      <= '0;
      MOSI_to_sensor <= 1'b0;
      SCLK_wire      <= 1'b0;
      CS_b_wire      <= 1'b1;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_idx         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      CS_b_wire <= !(next_state inside {SETUP, SHIFT, HOLD});

      if (state == IDLE || next_state != state || (state == SHIFT && half_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            frames_left <= num_frames;
            frame_idx   <= '0;
            if (num_frames == '0) done <= 1'b1;
            else                  busy <= 1'b1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            SCLK_wire <= ~SCLK_wire;
            if (!SCLK_wire) begin
              rx_sh <= {rx_sh[14:0], miso};
            end else if (bit_cnt != 4'd15) begin
              bit_cnt        <= bit_cnt + 1'b1;
              tx_sh          <= {tx_sh[14:0], 1'b0};
              MOSI_to_sensor <= tx_sh[14];
            end
          end
        end
        HOLD: begin
          // Publish on entry to GAP so rx_valid marks its first cycle.
          if (half_end) begin
            rx_data     <= rx_sh;
            rx_valid    <= 1'b1;
            rx_idx      <= frame_idx;
            frame_idx   <= frame_idx + 1'b1;
            frames_left <= frames_left - 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST && frames_left == '0) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (frame_begin) begin
        tx_sh          <= cmd_word;
        MOSI_to_sensor <= cmd_word[15];
        bit_cnt        <= '0;
        SCLK_wire      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_frame_master.sv
// Directed bench for spi_sensor_frame_master with a mode-0 sensor model and an rx scoreboard.
module tb_spi_sensor_frame_master;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_frames = '0;
  logic [15:0]      cmd_word = '0;
  logic             miso_line;
  logic             MOSI_to_sensor, SCLK_wire, CS_b_wire, sample_CLK_out;
  logic [15:0]      rx_data;
  logic             rx_valid;
  logic [CNT_W-1:0] rx_idx;
  logic             busy, done;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic             loopback_sel = 1'b0;
`endif

  spi_sensor_frame_master dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_frames       (num_frames),
    .cmd_word         (cmd_word),
    .MISO_from_sensor (miso_line),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback_sel     (loopback_sel),
`endif
    .MOSI_to_sensor   (MOSI_to_sensor),
    .SCLK_wire        (SCLK_wire),
    .CS_b_wire        (CS_b_wire),
    .sample_CLK_out   (sample_CLK_out),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_idx           (rx_idx),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      data;
    logic [CNT_W-1:0] idx;
  } rx_exp_t;

  rx_exp_t     sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          done_count = 0;
  int          rx_count = 0;
  int unsigned done_cyc = 0;
  int unsigned busy_rise_cyc = 0;
  int unsigned last_rx_cyc = 0;
  bit          have_last_rx = 0;
  bit          busy_d = 0;
  int          cs_high_run = 0;
  int          sclk_rises = 0;
  logic [15:0] mosi_cap = '0;

  // Sensor model: presents bit 15 when CS falls, advances on each SCLK fall.
  logic [15:0] sens_base = 16'h0000;
  logic [15:0] sens_word = 16'h0000;
  logic [3:0]  sens_bit = 4'd15;
  int          sens_frame = 0;

  assign miso_line = sens_word[sens_bit];

  always @(negedge CS_b_wire) begin
    sens_word = sens_base ^ {sens_frame[7:0], sens_frame[7:0]};
    sens_bit  = 4'd15;
    sens_frame++;
  end

  always @(negedge SCLK_wire) begin
    if (!CS_b_wire && sens_bit != 4'd0) sens_bit = sens_bit - 4'd1;
  end

  always @(posedge SCLK_wire) begin
    sclk_rises++;
    mosi_cap = {mosi_cap[14:0], MOSI_to_sensor};
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, frame spacing, CS gap width, done bookkeeping.
  always @(negedge clk) begin
    if (reset) begin
      if (busy && !busy_d) busy_rise_cyc = cyc;
      busy_d = busy;
      if (done) begin
        done_count++;
        done_cyc = cyc;
        checkOutput("busy_low_at_done", 32'(busy), 32'd0);
      end
      if (rx_valid) begin
        rx_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_rx", 32'(sb.size()), 32'd1);
        end else begin
          rx_exp_t e;
          e = sb.pop_front();
          checkOutput("rx_data", 32'(rx_data), 32'(e.data));
          checkOutput("rx_idx", 32'(rx_idx), 32'(e.idx));
        end
        if (have_last_rx) checkOutput("rx_spacing", cyc - last_rx_cyc, 32'd80);
        have_last_rx = 1;
        last_rx_cyc  = cyc;
      end
      if (busy && CS_b_wire) begin
        cs_high_run++;
      end else begin
        if (busy && cs_high_run > 0) checkOutput("cs_gap", 32'(cs_high_run), 32'd12);
        cs_high_run = 0;
      end
    end else begin
      busy_d = 0;
      cs_high_run = 0;
    end
  end

  task automatic applyStimulus(input int n, input bit loopback);
    rx_exp_t e;
    sens_frame   = 0;
    have_last_rx = 0;
    for (int i = 0; i < n; i++) begin
      e.data = loopback ? cmd_word : (sens_base ^ {i[7:0], i[7:0]});
      e.idx  = CNT_W'(i);
      sb.push_back(e);
    end
    @(negedge clk);
    num_frames = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int budget);
    int left;
    left = budget;
    while (done_count == d0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    checkOutput("done_seen", 32'(done_count > d0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int  d0;
    int  r0;
    bit  busy_seen;
    bit  cs_low_seen;

    $display("[TB] reset values");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_cs_b", 32'(CS_b_wire), 32'd1);
    checkOutput("rst_sclk", 32'(SCLK_wire), 32'd0);
    checkOutput("rst_mosi", 32'(MOSI_to_sensor), 32'd0);
    checkOutput("rst_sample_clk", 32'(sample_CLK_out), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_idx", 32'(rx_idx), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single frame");
    cmd_word   = 16'hA5C3;
    sens_base  = 16'h1234;
    sclk_rises = 0;
    mosi_cap   = '0;
    d0 = done_count;
    r0 = rx_count;
    applyStimulus(1, 0);
    checkOutput("sample_clk_during_frame", 32'(sample_CLK_out), 32'd1);
    waitDone(d0, 200);
    checkOutput("sclk_rises", 32'(sclk_rises), 32'd16);
    checkOutput("mosi_bits", 32'(mosi_cap), 32'h0000A5C3);
    checkOutput("done_latency", done_cyc - busy_rise_cyc, 32'd80);
    checkOutput("single_rx_count", 32'(rx_count - r0), 32'd1);
    checkOutput("single_done_count", 32'(done_count - d0), 32'd1);
    checkOutput("single_cs_idle", 32'(CS_b_wire), 32'd1);

    $display("[TB] burst of 31 with stray start");
    cmd_word  = 16'h0F0F;
    sens_base = 16'hC0DE;
    d0 = done_count;
    r0 = rx_count;
    applyStimulus(31, 0);
    repeat (300) @(negedge clk);
    num_frames = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_frames = 16'd3;
    waitDone(d0, 31 * 80 + 200);
    checkOutput("burst_rx_count", 32'(rx_count - r0), 32'd31);
    checkOutput("burst_done_count", 32'(done_count - d0), 32'd1);
    checkOutput("burst_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] second burst of 5");
    sens_base = 16'h8001;
    d0 = done_count;
    r0 = rx_count;
    applyStimulus(5, 0);
    waitDone(d0, 5 * 80 + 200);
    checkOutput("burst5_rx_count", 32'(rx_count - r0), 32'd5);
    checkOutput("burst5_done_count", 32'(done_count - d0), 32'd1);
    checkOutput("burst5_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] zero count");
    d0 = done_count;
    @(negedge clk);
    num_frames = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_done_pulse", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    busy_seen = 0;
    cs_low_seen = 0;
    repeat (10) begin
      @(negedge clk);
      busy_seen   = busy_seen | busy;
      cs_low_seen = cs_low_seen | !CS_b_wire;
    end
    checkOutput("zero_busy_never", 32'(busy_seen), 32'd0);
    checkOutput("zero_cs_idle", 32'(cs_low_seen), 32'd0);
    checkOutput("zero_done_count", 32'(done_count - d0), 32'd1);

    $display("[TB] reset mid-burst");
    sens_base = 16'h3C3C;
    d0 = done_count;
    r0 = rx_count;
    applyStimulus(4, 0);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_cs_b", 32'(CS_b_wire), 32'd1);
    checkOutput("abort_sclk", 32'(SCLK_wire), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    repeat (200) @(negedge clk);
    checkOutput("abort_rx_count", 32'(rx_count - r0), 32'd1);
    checkOutput("abort_done_count", 32'(done_count - d0), 32'd0);
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);
    checkOutput("abort_idle_cs", 32'(CS_b_wire), 32'd1);

`ifdef SPI_MASTER_LOOPBACK_EN
    $display("[TB] loopback");
    loopback_sel = 1'b1;
    cmd_word  = 16'hBEEF;
    sens_base = 16'h5A5A;
    d0 = done_count;
    r0 = rx_count;
    applyStimulus(3, 1);
    waitDone(d0, 3 * 80 + 200);
    checkOutput("loop_rx_count", 32'(rx_count - r0), 32'd3);
    checkOutput("loop_sb_empty", 32'(sb.size()), 32'd0);
    loopback_sel = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
